// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control/execute block: ALU control codes,
// aluop and funct fields, and the FSM state type.
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] ALUCT_AND  = 4'b0000;
    localparam logic [3:0] ALUCT_OR   = 4'b0001;
    localparam logic [3:0] ALUCT_ADD  = 4'b0010;
    localparam logic [3:0] ALUCT_XOR  = 4'b0011;
    localparam logic [3:0] ALUCT_SUB  = 4'b0110;
    localparam logic [3:0] ALUCT_SLT  = 4'b0111;
    localparam logic [3:0] ALUCT_SLTU = 4'b1000;
    localparam logic [3:0] ALUCT_NOR  = 4'b1100;

    // aluop field from the main control FSM
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    // R-type funct field
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational aluop/funct decoder: ALU control code plus operation-class flags.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] aluct,
    output logic       is_mul,
    output logic       is_div,
    output logic       is_signed,
    output logic       is_mfhi,
    output logic       is_mflo,
    output logic       illegal
);

    // Map aluop/funct onto a control code; mult/div/mfhi/mflo/illegal are flagged separately
    always_comb begin
        aluct     = ALUCT_ADD;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_mfhi   = 1'b0;
        is_mflo   = 1'b0;
        illegal   = 1'b0;
        case (aluop)
            ALUOP_ADD: aluct = ALUCT_ADD;
            ALUOP_SUB: aluct = ALUCT_SUB;
            ALUOP_SLT: aluct = ALUCT_SLT;
            default: begin
                case (funct)
                    F_ADD, F_ADDU: aluct = ALUCT_ADD;
                    F_SUB, F_SUBU: aluct = ALUCT_SUB;
                    F_AND:         aluct = ALUCT_AND;
                    F_OR:          aluct = ALUCT_OR;
                    F_XOR:         aluct = ALUCT_XOR;
                    F_NOR:         aluct = ALUCT_NOR;
                    F_SLT:         aluct = ALUCT_SLT;
                    F_SLTU:        aluct = ALUCT_SLTU;
                    F_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
                    F_MULTU:       is_mul = 1'b1;
                    F_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
                    F_DIVU:        is_div = 1'b1;
                    F_MFHI:        is_mfhi = 1'b1;
                    F_MFLO:        is_mflo = 1'b1;
                    default:       illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_exec.sv
// Registered ALU execute stage with iterative multiply/divide and HI/LO.
// Signed mult/div run on operand magnitudes; signs are restored on the last step.
module alu_ctrl_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             illegal,
    output logic             div0
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opd;
    logic             op_div, neg_q, neg_r;

    logic [3:0]       aluct;
    logic             is_mul, is_div, is_signed, is_mfhi, is_mflo, dec_ill;

    alu_decode u_dec (
        .aluop     (aluop),
        .funct     (funct),
        .aluct     (aluct),
        .is_mul    (is_mul),
        .is_div    (is_div),
        .is_signed (is_signed),
        .is_mfhi   (is_mfhi),
        .is_mflo   (is_mflo),
        .illegal   (dec_ill)
    );

    logic             accept, go_iter, div0_c, last;
    logic             sa, sb;
    logic [WIDTH-1:0] ma, mb, sc_res;
    logic [WIDTH:0]   msum;
    logic [WIDTH+1:0] ddiff;
    logic [WIDTH:0]   dsh;
    logic [WIDTH-1:0] step_h, step_l, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod;

    assign accept  = start && (state != S_ITER);
    assign div0_c  = is_div && (b == '0);
    assign go_iter = accept && (is_mul || (is_div && !div0_c));
    assign last    = (state == S_ITER) && (cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next state and handshake outputs; start is honoured in IDLE and FIN
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nx = go_iter ? S_ITER : S_FIN;
            S_ITER: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) state_nx = S_FIN;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = accept ? (go_iter ? S_ITER : S_FIN) : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Single-cycle result, operand magnitudes, one iteration step and sign fix-up
    always_comb begin
        sa = is_signed && a[WIDTH-1];
        sb = is_signed && b[WIDTH-1];
        ma = sa ? -a : a;
        mb = sb ? -b : b;

        case (aluct)
            ALUCT_AND:  sc_res = a & b;
            ALUCT_OR:   sc_res = a | b;
            ALUCT_XOR:  sc_res = a ^ b;
            ALUCT_NOR:  sc_res = ~(a | b);
            ALUCT_SUB:  sc_res = a - b;
            ALUCT_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALUCT_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
            default:    sc_res = a + b;
        endcase
        if (dec_ill)      sc_res = '0;
        else if (is_mfhi) sc_res = hi;
        else if (is_mflo) sc_res = lo;
        else if (div0_c)  sc_res = '1;

        // shift-add: acc_lo holds the multiplier, shifted out LSB first
        msum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
        // restoring divide: acc_hi is the partial remainder, acc_lo the quotient
        dsh   = {acc_hi, acc_lo[WIDTH-1]};
        ddiff = {1'b0, dsh} - {2'b0, opd};
        if (op_div) begin
            step_h = ddiff[WIDTH+1] ? dsh[WIDTH-1:0] : ddiff[WIDTH-1:0];
            step_l = {acc_lo[WIDTH-2:0], ~ddiff[WIDTH+1]};
        end else begin
            step_h = msum[WIDTH:1];
            step_l = {msum[0], acc_lo[WIDTH-1:1]};
        end

        prod = neg_q ? -{step_h, step_l} : {step_h, step_l};
        if (op_div) begin
            fin_lo = neg_q ? -step_l : step_l;
            fin_hi = neg_r ? -step_h : step_h;
        end else begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    // Datapath: operand load, iteration, and completion registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opd     <= '0;
            op_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            illegal <= 1'b0;
            div0    <= 1'b0;
        end else if (accept) begin
            if (go_iter) begin
                acc_hi <= '0;
                acc_lo <= ma;
                opd    <= mb;
                cnt    <= CNT_W'(WIDTH);
                op_div <= is_div;
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
            end else begin
                result  <= sc_res;
                zero    <= (sc_res == '0);
                illegal <= dec_ill;
                div0    <= div0_c;
                if (div0_c) begin
                    hi <= a;
                    lo <= '1;
                end
            end
        end else if (state == S_ITER) begin
            acc_hi <= step_h;
            acc_lo <= step_l;
            cnt    <= cnt - CNT_W'(1);
            if (last) begin
                hi      <= fin_hi;
                lo      <= fin_lo;
                result  <= fin_lo;
                zero    <= (fin_lo == '0);
                illegal <= 1'b0;
                div0    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed bench for alu_ctrl_exec with hand-computed expected values.
module tb_alu_ctrl_exec;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic         busy, done, zero, illegal, div0;
    logic [W-1:0] result, hi, lo;

    int pass_cnt = 0;
    int total    = 0;
    int lat;
    logic seen;

    alu_ctrl_exec #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero),
        .hi(hi), .lo(lo), .illegal(illegal), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // drive a request, let it be sampled at the next edge, sample #1 after it
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] va, input logic [W-1:0] vb);
        aluop = op; funct = fn; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // latency in cycles from the sampling edge until done is seen (1 = next cycle)
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) n = -1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; aluop = 2'b00; funct = 6'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_flags", {illegal, div0}, 0);
        reset = 1'b0;

        // 1: sub via funct, then add of zeros
        issue(ALUOP_FUNCT, F_SUB, 5, 7); wait_done(lat);
        chk("sub_lat", lat, 1);
        chk("sub_res", result, 32'hFFFF_FFFE);
        chk("sub_zero", zero, 0);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        issue(ALUOP_ADD, 6'd0, 0, 0); wait_done(lat);
        chk("add0_res", result, 0);
        chk("add0_zero", zero, 1);

        // 2: slt/sltu/nor, issued back-to-back in FIN
        issue(ALUOP_SLT, 6'd0, 32'hFFFF_FFFF, 1); wait_done(lat);
        chk("slt_res", result, 1);
        issue(ALUOP_FUNCT, F_SLTU, 32'hFFFF_FFFF, 1); wait_done(lat);
        chk("sltu_lat", lat, 1);
        chk("sltu_res", result, 0);
        issue(ALUOP_FUNCT, F_NOR, 0, 0); wait_done(lat);
        chk("nor_res", result, 32'hFFFF_FFFF);

        // 3: mult / multu
        issue(ALUOP_FUNCT, F_MULT, 32'hFFFF_FFFE, 3);
        chk("mult_busy", busy, 1);
        wait_done(lat);
        chk("mult_lat", lat, W + 1);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("mult_res", result, 32'hFFFF_FFFA);
        issue(ALUOP_FUNCT, F_MULTU, 32'hFFFF_FFFE, 3); wait_done(lat);
        chk("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        // 4: divides
        issue(ALUOP_FUNCT, F_DIV, 32'hFFFF_FFF9, 2); wait_done(lat);
        chk("div_lat", lat, W + 1);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(ALUOP_FUNCT, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(lat);
        chk("divmin_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        issue(ALUOP_FUNCT, F_DIVU, 100, 7); wait_done(lat);
        chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});
        issue(ALUOP_FUNCT, F_DIVU, 7, 0); wait_done(lat);
        chk("div0_lat", lat, 1);
        chk("div0_flag", div0, 1);
        chk("div0_hilo", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
        issue(ALUOP_ADD, 6'd0, 1, 1); wait_done(lat);
        chk("div0_clear", div0, 0);

        // 5a: start during ITER is ignored
        issue(ALUOP_FUNCT, F_MULTU, 6, 7);
        repeat (5) @(posedge clk);
        #1;
        aluop = ALUOP_ADD; a = 9; b = 9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("ign_lat", lat + 6, W + 1);
        chk("ign_hilo", {hi, lo}, {32'd0, 32'd42});
        chk("ign_res", result, 42);

        // 5b: reset at cycle 10 of a mult
        @(posedge clk); #1;
        issue(ALUOP_FUNCT, F_MULT, 3, 5);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hilo", {hi, lo}, 0);
        seen = done;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen = seen | done;
        end
        chk("abort_nodone", seen, 0);
        issue(ALUOP_FUNCT, F_MFHI, 0, 0); wait_done(lat);
        chk("abort_mfhi", result, 0);

        // 6: illegal funct leaves hi/lo, next valid op clears the flag
        issue(ALUOP_FUNCT, F_MULTU, 32'h0001_0000, 32'h0003_0000); wait_done(lat);
        chk("big_hilo", {hi, lo}, 64'h0000_0003_0000_0000);
        issue(ALUOP_FUNCT, 6'b111111, 5, 5); wait_done(lat);
        chk("ill_lat", lat, 1);
        chk("ill_flag", illegal, 1);
        chk("ill_res", result, 0);
        chk("ill_hilo", {hi, lo}, 64'h0000_0003_0000_0000);
        issue(ALUOP_FUNCT, F_MFHI, 0, 0); wait_done(lat);
        chk("mfhi_res", result, 3);
        issue(ALUOP_FUNCT, F_XOR, 32'hF0F0_0000, 32'h0FF0_000F); wait_done(lat);
        chk("xor_res", result, 32'hFF00_000F);
        chk("ill_clear", illegal, 0);
        issue(ALUOP_FUNCT, F_ADDU, 1, 2); wait_done(lat);
        chk("add_res", result, 3);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
